pushbutton_debouncer: RTL

- Conditions the raw board pushbuttons (KEY[3:0]) before the Avalon PIO input port.
- Synchronizes each asynchronous input with a 2-FF chain, then debounces it with a per-button stability counter.
- Outputs a clean active-high pressed level for the PIO in_port, plus one-cycle press and release pulses for game logic (paddle, launch, pause).

---
 rtl/pushbutton_debouncer.sv | 68 ++++++
 1 files changed

// File: rtl/pushbutton_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer plus per-button stability counter.
// Produces a clean pressed level and one-cycle press/release pulses per channel.
module pushbutton_debouncer #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] key_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    localparam logic [NUM_BUTTONS-1:0] RELEASED = {NUM_BUTTONS{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] raw_pressed;
    logic [CNT_WIDTH-1:0]   cnt [NUM_BUTTONS];

    // Synchronizer resets to the idle pin level so a held button is not seen
    // as pressed until it has passed through the chain after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign raw_pressed = sync2 ^ RELEASED;

    // Counter only runs while the sampled level disagrees with the accepted one;
    // any agreeing sample restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (raw_pressed[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i]         <= '0;
                    btn_level[i]   <= raw_pressed[i];
                    btn_press[i]   <= raw_pressed[i];
                    btn_release[i] <= ~raw_pressed[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

endmodule
